// File: rtl/input_debouncer_if.sv
// Signal bundle between the raw-input conditioner and its consumer.
// The master side drives the raw pins and the clear mask; the slave side
// (the debouncer) returns the clean level, edge pulses and event flags.
interface input_debouncer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] switch_in;
    logic [WIDTH-1:0] event_clear;
    logic [WIDTH-1:0] switch_level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] event_pending;
    logic             any_pending;

    modport master (
        output switch_in,
        output event_clear,
        input  switch_level,
        input  rise,
        input  fall,
        input  event_pending,
        input  any_pending
    );

    modport slave (
        input  switch_in,
        input  event_clear,
        output switch_level,
        output rise,
        output fall,
        output event_pending,
        output any_pending
    );
endinterface

// File: rtl/input_debouncer.sv
// Per-bit input conditioner: two-flop synchroniser, stability-counter
// debounce, single-cycle rise/fall pulses and sticky write-one-to-clear
// event flags. Every bit is independent; single clock domain.
module input_debouncer #(
    parameter int          WIDTH         = 4,
    parameter logic [31:0] STABLE_CYCLES = 32'd1_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input_debouncer_if.slave     bus
);

    // Counter only needs to reach STABLE_CYCLES-1; never narrower than one bit.
    localparam int CNT_W = (STABLE_CYCLES > 32'd2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_FLIP     = 2'd2
    } dstate_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_level;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_pend;
    logic             r_any;

    logic [WIDTH-1:0] w_mismatch;
    dstate_t          w_state [WIDTH];
    logic [CNT_W-1:0] w_cnt_next [WIDTH];
    logic [WIDTH-1:0] w_level_next;
    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_fall_next;
    logic [WIDTH-1:0] w_pend_next;

    assign w_mismatch = r_sync2 ^ r_level;

    // Two-flop synchroniser; only the second stage feeds the debounce logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.switch_in;
            r_sync2 <= r_sync1;
        end
    end

    // Classify each bit: idle, still counting, or stable long enough to flip.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_state[i] = ST_IDLE;
            if (w_mismatch[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_state[i] = ST_FLIP;
                end else begin
                    w_state[i] = ST_COUNTING;
                end
            end
        end
    end

    // Next counter and level per bit; the counter saturates by flipping, never wraps.
    always_comb begin
        w_level_next = r_level;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            case (w_state[i])
                ST_COUNTING: w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                ST_FLIP:     w_level_next[i] = ~r_level[i];
                default:     w_cnt_next[i] = '0;
            endcase
        end
    end

    // Edge pulses and event flags; a new event beats a simultaneous clear.
    always_comb begin
        w_rise_next = '0;
        w_fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_state[i] == ST_FLIP) begin
                w_rise_next[i] = ~r_level[i];
                w_fall_next[i] = r_level[i];
            end
        end
        w_pend_next = (r_pend & ~bus.event_clear) | w_rise_next | w_fall_next;
    end

    // Debounce state, pulses and flags; any_pending uses the next-state flags
    // so it updates on the same edge as event_pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_pend  <= '0;
            r_any   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
            r_pend  <= w_pend_next;
            r_any   <= |w_pend_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign bus.switch_level  = r_level;
    assign bus.rise          = r_rise;
    assign bus.fall          = r_fall;
    assign bus.event_pending = r_pend;
    assign bus.any_pending   = r_any;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer with a scoreboard fed
// by a window-based reference model of the debounce rules.
module tb_input_debouncer;

    localparam int W = 4;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] pend;
        logic         any;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    input_debouncer_if #(.WIDTH(W)) bus ();

    input_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (32'(S))
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sbq[$];

    // Reference model state: raw samples applied at each edge since reset.
    logic [W-1:0] samp[$];
    logic [W-1:0] m_level;
    logic [W-1:0] m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int k = 0; k < S + 3; k++) samp.push_back('0);
        m_level = '0;
        m_pend  = '0;
    endtask

    // The level of a bit flips when the last S synchronised samples (raw
    // input delayed by two edges) all disagree with the current level.
    task automatic model_edge(input logic [W-1:0] sw, input logic [W-1:0] clr);
        exp_t e;
        logic [W-1:0] flip;
        samp.push_back(sw);
        flip = '0;
        for (int b = 0; b < W; b++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int j = 0; j < S; j++) begin
                if (samp[samp.size() - 3 - j][b] == m_level[b]) all_diff = 1'b0;
            end
            flip[b] = all_diff;
        end
        e.rise  = flip & ~m_level;
        e.fall  = flip & m_level;
        m_level = m_level ^ flip;
        m_pend  = (m_pend & ~clr) | flip;
        e.level = m_level;
        e.pend  = m_pend;
        e.any   = |m_pend;
        sbq.push_back(e);
        while (samp.size() > S + 4) void'(samp.pop_front());
    endtask

    task automatic step(input logic [W-1:0] sw, input logic [W-1:0] clr);
        bus.switch_in   = sw;
        bus.event_clear = clr;
        @(posedge clk);
        model_edge(sw, clr);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] sw);
        @(negedge clk);
        #1;
        reset = 1'b0;
        bus.switch_in = sw;
        bus.event_clear = '0;
        #1;
        chk("rst_level", 32'(bus.switch_level), 32'h0);
        chk("rst_rise",  32'(bus.rise), 32'h0);
        chk("rst_fall",  32'(bus.fall), 32'h0);
        chk("rst_pend",  32'(bus.event_pending), 32'h0);
        chk("rst_any",   32'(bus.any_pending), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_level", 32'(bus.switch_level), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Scoreboard monitor: one expected entry per clock edge, checked mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_level", 32'(bus.switch_level), 32'(e.level));
            chk("sb_rise",  32'(bus.rise), 32'(e.rise));
            chk("sb_fall",  32'(bus.fall), 32'(e.fall));
            chk("sb_pend",  32'(bus.event_pending), 32'(e.pend));
            chk("sb_any",   32'(bus.any_pending), 32'(e.any));
            chk("sb_rise_and_fall", 32'(bus.rise & bus.fall), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fall_cnt;
        int fall_at;
        logic [W-1:0] val;
        int hold;

        bus.switch_in   = '0;
        bus.event_clear = '0;
        model_reset();
        do_reset(4'h0);

        // Randomised phase: inputs held for random durations so some flips land.
        for (int n = 0; n < 60; n++) begin
            val  = W'($urandom);
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                step(val, ($urandom_range(0, 3) == 0) ? W'($urandom) : '0);
            end
        end

        // Asynchronous reset with all inputs high.
        do_reset(4'hF);

        // Clean press on bit 0.
        for (int i = 0; i < 6; i++) begin
            step(4'b0001, '0);
            if (i == 4) chk("press_level_early", 32'(bus.switch_level), 32'h0);
        end
        chk("press_level", 32'(bus.switch_level), 32'h1);
        chk("press_rise",  32'(bus.rise), 32'h1);
        chk("press_pend",  32'(bus.event_pending), 32'h1);
        chk("press_any",   32'(bus.any_pending), 32'h1);
        step(4'b0001, '0);
        chk("press_rise_end", 32'(bus.rise), 32'h0);
        step(4'b0001, 4'b0001);
        chk("clear_pend", 32'(bus.event_pending), 32'h0);
        chk("clear_any",  32'(bus.any_pending), 32'h0);

        // Glitch rejection on bit 2.
        for (int r = 0; r < 5; r++) begin
            repeat (3) step(4'b0101, '0);
            repeat (3) step(4'b0001, '0);
        end
        chk("glitch_level", 32'(bus.switch_level), 32'h1);
        chk("glitch_pend",  32'(bus.event_pending), 32'h0);

        // Release with bounce on bit 0.
        fall_cnt = 0;
        fall_at  = -1;
        for (int i = 0; i < 12; i++) begin
            step((i == 1) ? 4'b0001 : 4'b0000, '0);
            if (bus.fall[0]) begin
                fall_cnt++;
                fall_at = i;
            end
        end
        chk("bounce_fall_count", 32'(fall_cnt), 32'd1);
        chk("bounce_fall_edge",  32'(fall_at), 32'd7);
        chk("bounce_level",      32'(bus.switch_level), 32'h0);
        step(4'b0000, 4'b0001);

        // Set/clear collision on bit 1.
        repeat (6) step(4'b0010, '0);
        chk("coll_pend_set", 32'(bus.event_pending[1]), 32'h1);
        for (int j = 0; j < 6; j++) begin
            step(4'b0000, (j == 5) ? 4'b0010 : 4'b0000);
        end
        chk("coll_fall", 32'(bus.fall[1]), 32'h1);
        chk("coll_pend_kept", 32'(bus.event_pending[1]), 32'h1);
        step(4'b0000, 4'b0010);
        chk("coll_clear", 32'(bus.event_pending[1]), 32'h0);
        step(4'b0000, 4'b0000);
        chk("coll_clear_hold", 32'(bus.event_pending[1]), 32'h0);

        // Reset released mid-count on bit 3.
        repeat (3) step(4'b1000, '0);
        do_reset(4'b1000);
        for (int i = 0; i < 6; i++) begin
            step(4'b1000, '0);
            if (i == 4) chk("rmid_level_early", 32'(bus.switch_level[3]), 32'h0);
        end
        chk("rmid_level", 32'(bus.switch_level[3]), 32'h1);
        chk("rmid_rise",  32'(bus.rise[3]), 32'h1);
        chk("rmid_pend",  32'(bus.event_pending[3]), 32'h1);
        step(4'b1000, '0);
        chk("rmid_rise_end", 32'(bus.rise[3]), 32'h0);

        // More random traffic after the directed cases.
        for (int n = 0; n < 40; n++) begin
            val  = W'($urandom);
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                step(val, ($urandom_range(0, 2) == 0) ? W'($urandom) : '0);
            end
        end

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
